// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one fixed-point divider
// among NUM_REQ requesters. It takes one request at a time, drives the
// divider start/done handshake and returns the quotient and status flags
// to the requester that was granted. A watchdog sends back a timeout
// response if the divider never reports done.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   req                 level request, one bit per requester
//   req_a, req_b        dividend / divisor for each requester
//   gnt                 one-hot, 1-cycle pulse: operands captured
//   rsp_valid           one-hot, 1-cycle pulse: response for that requester
//   rsp_val, rsp_*      shared response bus; holds until the next response
//   busy                high in ISSUE, WAIT and RESPOND
//   div_start/a/b       to the divider
//   div_busy/done/...   from the divider
module div_arbiter #(
  parameter int WIDTH   = 16,
  parameter int FBITS   = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic signed [NUM_REQ-1:0][WIDTH-1:0] req_a,
  input  logic signed [NUM_REQ-1:0][WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic signed [WIDTH-1:0]              rsp_val,
  output logic                                 rsp_ok,
  output logic                                 rsp_dbz,
  output logic                                 rsp_ovf,
  output logic                                 rsp_timeout,
  output logic                                 busy,
  output logic                                 div_start,
  output logic signed [WIDTH-1:0]              div_a,
  output logic signed [WIDTH-1:0]              div_b,
  input  logic                                 div_busy,
  input  logic                                 div_done,
  input  logic                                 div_valid,
  input  logic                                 div_dbz,
  input  logic                                 div_ovf,
  input  logic signed [WIDTH-1:0]              div_val
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                    r_state, w_state;
  logic [PW-1:0]             r_ptr, w_ptr, r_owner, w_owner;
  logic [CW-1:0]             r_cnt, w_cnt;
  logic [NUM_REQ-1:0]        r_gnt, w_gnt, r_rsp_valid, w_rsp_valid;
  logic signed [WIDTH-1:0]   r_rsp_val, w_rsp_val, r_a, w_a, r_b, w_b;
  logic                      r_ok, w_ok, r_dbz, w_dbz, r_ovf, w_ovf;
  logic                      r_tmo, w_tmo, r_busy, w_busy, r_start, w_start;

  logic                      w_hit;
  logic [PW-1:0]             w_sel, w_cand, w_sel_nxt;

  // Round-robin pick: first set req bit starting at r_ptr, wrapping.
  always_comb begin
    w_hit  = 1'b0;
    w_sel  = '0;
    w_cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = PW'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_hit && req[w_cand]) begin
        w_hit = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  assign w_sel_nxt = (w_sel == PW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;

  always_comb begin
    w_state     = r_state;
    w_ptr       = r_ptr;
    w_owner     = r_owner;
    w_cnt       = r_cnt;
    w_gnt       = r_gnt;
    w_rsp_valid = r_rsp_valid;
    w_rsp_val   = r_rsp_val;
    w_ok        = r_ok;
    w_dbz       = r_dbz;
    w_ovf       = r_ovf;
    w_tmo       = r_tmo;
    w_start     = r_start;
    w_a         = r_a;
    w_b         = r_b;
    case (r_state)
      S_IDLE: begin
        // A divider still busy from a timed-out job blocks new grants.
        if (w_hit && !div_busy) begin
          w_a          = req_a[w_sel];
          w_b          = req_b[w_sel];
          w_gnt        = '0;
          w_gnt[w_sel] = 1'b1;
          w_start      = 1'b1;
          w_owner      = w_sel;
          w_ptr        = w_sel_nxt;
          w_state      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_gnt   = '0;
        w_start = 1'b0;
        w_cnt   = '0;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        // done wins over the watchdog when both land in the same cycle.
        if (div_done) begin
          w_rsp_val            = div_val;
          w_ok                 = div_valid;
          w_dbz                = div_dbz;
          w_ovf                = div_ovf;
          w_tmo                = 1'b0;
          w_rsp_valid          = '0;
          w_rsp_valid[r_owner] = 1'b1;
          w_state              = S_RESP;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_rsp_val            = '0;
          w_ok                 = 1'b0;
          w_dbz                = 1'b0;
          w_ovf                = 1'b0;
          w_tmo                = 1'b1;
          w_rsp_valid          = '0;
          w_rsp_valid[r_owner] = 1'b1;
          w_state              = S_RESP;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_RESP: begin
        w_rsp_valid = '0;
        w_state     = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_val   <= '0;
      r_ok        <= 1'b0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      r_tmo       <= 1'b0;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
    end else begin
      r_state     <= w_state;
      r_ptr       <= w_ptr;
      r_owner     <= w_owner;
      r_cnt       <= w_cnt;
      r_gnt       <= w_gnt;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_val   <= w_rsp_val;
      r_ok        <= w_ok;
      r_dbz       <= w_dbz;
      r_ovf       <= w_ovf;
      r_tmo       <= w_tmo;
      r_busy      <= w_busy;
      r_start     <= w_start;
      r_a         <= w_a;
      r_b         <= w_b;
    end
  end

  assign gnt         = r_gnt;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_val     = r_rsp_val;
  assign rsp_ok      = r_ok;
  assign rsp_dbz     = r_dbz;
  assign rsp_ovf     = r_ovf;
  assign rsp_timeout = r_tmo;
  assign busy        = r_busy;
  assign div_start   = r_start;
  assign div_a       = r_a;
  assign div_b       = r_b;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural divider (latency D,
// or a "hang" mode that never reports done in time and then drops busy
// together with a late done pulse).
module tb_div_arbiter;
  localparam int W = 16, FB = 8, N = 4, TO = 8, D = 3, HANG = 14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] hold = '0;
  logic [N-1:0][W-1:0] req_a = '0, req_b = '0;
  logic [N-1:0] gnt, rsp_valid;
  logic [W-1:0] rsp_val, div_a, div_b;
  logic rsp_ok, rsp_dbz, rsp_ovf, rsp_timeout, busy, div_start;
  logic dbusy, ddone, dvalid, ddbz, dovf;
  logic [W-1:0] dval;

  always #5 clk = ~clk;

  div_arbiter #(.WIDTH(W), .FBITS(FB), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_val(rsp_val), .rsp_ok(rsp_ok),
    .rsp_dbz(rsp_dbz), .rsp_ovf(rsp_ovf), .rsp_timeout(rsp_timeout),
    .busy(busy), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_busy(dbusy), .div_done(ddone), .div_valid(dvalid), .div_dbz(ddbz),
    .div_ovf(dovf), .div_val(dval)
  );

  // ---------------- divider model ----------------
  logic hang = 1'b0;
  logic dhang;
  int dcnt;
  logic [W-1:0] la, lb;
  longint q_m;
  always_comb q_m = (lb == 0) ? 0 : (longint'($signed(la)) * 256) / longint'($signed(lb));

  always @(posedge clk) begin
    if (reset) begin
      dbusy <= 1'b0; ddone <= 1'b0; dcnt <= 0; dhang <= 1'b0;
      dvalid <= 1'b0; ddbz <= 1'b0; dovf <= 1'b0; dval <= '0; la <= '0; lb <= '0;
    end else begin
      ddone <= 1'b0;
      if (div_start) begin
        dbusy <= 1'b1; dcnt <= 1; la <= div_a; lb <= div_b; dhang <= hang;
      end else if (dbusy) begin
        if (dhang && dcnt == HANG - 1) begin
          dbusy <= 1'b0; ddone <= 1'b1; dval <= 16'h7777; dvalid <= 1'b1;
          ddbz <= 1'b0; dovf <= 1'b0;
        end else if (!dhang && dcnt == D - 1) begin
          dbusy <= 1'b0; ddone <= 1'b1;
          if (lb == 0) begin
            dval <= '0; dvalid <= 1'b0; ddbz <= 1'b1; dovf <= 1'b0;
          end else if (q_m > 32767) begin
            dval <= 16'h7FFF; dvalid <= 1'b0; ddbz <= 1'b0; dovf <= 1'b1;
          end else if (q_m < -32768) begin
            dval <= 16'h8000; dvalid <= 1'b0; ddbz <= 1'b0; dovf <= 1'b1;
          end else begin
            dval <= W'(q_m); dvalid <= 1'b1; ddbz <= 1'b0; dovf <= 1'b0;
          end
        end else begin
          dcnt <= dcnt + 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {int idx; logic [W-1:0] a; logic [W-1:0] b; int gap;} gexp_t;
  typedef struct {int idx; logic [W-1:0] val; logic ok; logic dbz; logic ovf; logic tmo; int lat;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0, stall = 0;
  logic fin = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Monitor: samples on negedge, pops expectations whenever gnt/rsp_valid fire.
  initial begin
    gexp_t g;
    rexp_t r;
    logic rst_prev = 1'b0;
    int last_gnt = 0;
    forever begin
      @(negedge clk);
      if (reset && rst_prev)
        chk("reset_outputs", {gnt, rsp_valid, rsp_val, rsp_ok, rsp_dbz, rsp_ovf,
                              rsp_timeout, busy, div_start, div_a, div_b}, 64'd0);
      rst_prev = reset;
      if (!reset) begin
        if (div_start !== (gnt != 0)) chk("start_with_gnt", {63'd0, div_start}, {63'd0, gnt != 0});
        if (gnt != 0) begin
          if (gq.size() == 0) chk("unexpected_gnt", gnt, 0);
          else begin
            g = gq.pop_front();
            chk("gnt", gnt, 64'(1) << g.idx);
            chk("div_a", div_a, g.a);
            chk("div_b", div_b, g.b);
            chk("busy_at_gnt", busy, 1);
            if (g.gap != 0) chk("gnt_gap", cyc - last_gnt, g.gap);
          end
          last_gnt = cyc;
        end
        if (rsp_valid != 0) begin
          if (rq.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
          else begin
            r = rq.pop_front();
            chk("rsp_valid", rsp_valid, 64'(1) << r.idx);
            chk("rsp_val", rsp_val, r.val);
            chk("rsp_flags", {rsp_ok, rsp_dbz, rsp_ovf, rsp_timeout}, {r.ok, r.dbz, r.ovf, r.tmo});
            chk("rsp_latency", cyc - last_gnt, r.lat);
            chk("busy_at_rsp", busy, 1);
          end
        end
      end
      if (fin) begin
        chk("gnt_queue_drained", gq.size(), 0);
        chk("rsp_queue_drained", rq.size(), 0);
        chk("no_stall", stall, 0);
        summary();
      end
      if (cyc > 5000) begin
        errors++; checks++;
        $display("FAIL watchdog: cycle %0d exceeded budget 5000", cyc);
        summary();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
    req = req & ~(gnt & ~hold);  // requesters drop after seeing their gnt
  endtask

  task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[k] = a; req_b[k] = b;
  endtask

  task automatic pg(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
    gexp_t e; e.idx = k; e.a = a; e.b = b; e.gap = gap; gq.push_back(e);
  endtask

  task automatic pr(input int k, input logic [W-1:0] v, input logic ok, input logic dz,
                    input logic ov, input logic tm, input int lat);
    rexp_t e; e.idx = k; e.val = v; e.ok = ok; e.dbz = dz; e.ovf = ov; e.tmo = tm; e.lat = lat;
    rq.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((gq.size() != 0 || rq.size() != 0 || busy || dbusy) && n < budget) begin
      tick(); n++;
    end
    if (n >= budget) stall++;
    repeat (2) tick();
  endtask

  initial begin
    int n, g2;
    // Single request: 3.0 / 1.0; response D+1 cycles after gnt.
    repeat (3) tick();
    reset = 1'b0;
    set_op(0, 16'h0300, 16'h0100);
    pg(0, 16'h0300, 16'h0100, 0);
    pr(0, 16'h0300, 1, 0, 0, 0, D + 1);
    req[0] = 1'b1;
    wait_idle(100);

    // Simultaneous requests from reset: order 0,1,2,3, one per D+3 cycles.
    reset = 1'b1;
    set_op(0, 16'h0100, 16'h0200); set_op(1, 16'h0600, 16'h0200);
    set_op(2, 16'hFE00, 16'h0100); set_op(3, 16'h0100, 16'h0300);
    req = 4'hF;
    pg(0, 16'h0100, 16'h0200, 0); pg(1, 16'h0600, 16'h0200, D + 3);
    pg(2, 16'hFE00, 16'h0100, D + 3); pg(3, 16'h0100, 16'h0300, D + 3);
    pr(0, 16'h0080, 1, 0, 0, 0, D + 1); pr(1, 16'h0300, 1, 0, 0, 0, D + 1);
    pr(2, 16'hFE00, 1, 0, 0, 0, D + 1); pr(3, 16'h0055, 1, 0, 0, 0, D + 1);
    repeat (3) tick();
    reset = 1'b0;
    wait_idle(200);

    // Fairness: req[2] held; req[0] re-raised after first gnt[2]. Order 0,1,2,0,2.
    set_op(0, 16'h0200, 16'h0100); set_op(1, 16'h0080, 16'h0100); set_op(2, 16'h0100, 16'hFF00);
    pg(0, 16'h0200, 16'h0100, 0); pg(1, 16'h0080, 16'h0100, D + 3);
    pg(2, 16'h0100, 16'hFF00, D + 3); pg(0, 16'h0200, 16'h0100, D + 3);
    pg(2, 16'h0100, 16'hFF00, D + 3);
    pr(0, 16'h0200, 1, 0, 0, 0, D + 1); pr(1, 16'h0080, 1, 0, 0, 0, D + 1);
    pr(2, 16'hFF00, 1, 0, 0, 0, D + 1); pr(0, 16'h0200, 1, 0, 0, 0, D + 1);
    pr(2, 16'hFF00, 1, 0, 0, 0, D + 1);
    hold = 4'b0100;
    req = 4'b0111;
    n = 0; g2 = 0;
    while ((gq.size() != 0 || rq.size() != 0 || busy) && n < 300) begin
      tick(); n++;
      if (gnt[2]) begin
        g2++;
        if (g2 == 1) req[0] = 1'b1;
        if (g2 == 2) begin hold[2] = 1'b0; req[2] = 1'b0; end
      end
    end
    if (n >= 300) stall++;
    repeat (2) tick();

    // Divide by zero and overflow; ptr is 3 so requester 3 goes first.
    set_op(1, 16'h0100, 16'h0000); set_op(3, 16'h7F00, 16'h0010);
    pg(3, 16'h7F00, 16'h0010, 0); pg(1, 16'h0100, 16'h0000, D + 3);
    pr(3, 16'h7FFF, 0, 0, 1, 0, D + 1); pr(1, 16'h0000, 0, 1, 0, 0, D + 1);
    req = 4'b1010;
    wait_idle(200);

    // Timeout (TIMEOUT=8): rsp 9 cycles after gnt, i.e. cycle TO+2 counting
    // the request-sampling cycle as 0. Next grant waits for div_busy to fall.
    hang = 1'b1;
    set_op(2, 16'h0100, 16'h0100); set_op(0, 16'h0300, 16'h0100);
    pg(2, 16'h0100, 16'h0100, 0); pg(0, 16'h0300, 16'h0100, HANG + 1);
    pr(2, 16'h0000, 0, 0, 0, 1, TO + 1); pr(0, 16'h0300, 1, 0, 0, 0, D + 1);
    req[2] = 1'b1;
    n = 0;
    while ((gq.size() != 0 || rq.size() != 0 || busy || dbusy) && n < 300) begin
      tick(); n++;
      if (gnt[2]) req[0] = 1'b1;
      if (rsp_valid[2]) hang = 1'b0;
    end
    if (n >= 300) stall++;
    repeat (2) tick();

    // Reset in WAIT: no response for the aborted job; ptr back to 0.
    set_op(1, 16'h0100, 16'h0100);
    pg(1, 16'h0100, 16'h0100, 0);
    req[1] = 1'b1;
    n = 0;
    while (!gnt[1] && n < 50) begin tick(); n++; end
    if (n >= 50) stall++;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    set_op(0, 16'h0300, 16'h0100); set_op(3, 16'h0100, 16'h0400);
    pg(0, 16'h0300, 16'h0100, 0); pg(3, 16'h0100, 16'h0400, D + 3);
    pr(0, 16'h0300, 1, 0, 0, 0, D + 1); pr(3, 16'h0040, 1, 0, 0, 0, D + 1);
    req = 4'b1001;
    wait_idle(200);

    fin = 1'b1;
    repeat (5) tick();
    $display("FAIL end: monitor did not finish");
    $fatal(1);
  end

endmodule
